alun_pipe: RTL and testbench



---
 rtl/alun_pkg.sv | 27 ++
 rtl/alun_core.sv | 47 ++++
 rtl/alun_pipe.sv | 147 ++++++++++++++
 tb/tb_alun_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alun_pkg.sv
// Shared types for the pipelined ALU: opcode encoding and result flags.
package alun_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_XOR   = 3'd4,
    OP_NOTA  = 3'd5,
    OP_PASSB = 3'd6,
    OP_CMP   = 3'd7
  } op_e;

  typedef struct packed {
    logic cout;
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

  // Opcodes that go through the adder and therefore produce carry/overflow.
  function automatic logic is_arith(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/alun_core.sv
// Combinational ALU datapath: one shared adder for ADD/SUB/CMP plus logic ops.
module alun_core
  import alun_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output flags_t           flags
);

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH:0]   sum;
  logic             arith;

  // Adder operand selection: subtract/compare add the inverted b; CMP forces carry-in.
  always_comb begin
    arith = is_arith(op);
    b_eff = (op == OP_ADD) ? b : ~b;
    c_eff = (op == OP_CMP) ? 1'b1 : cin;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
  end

  // Result mux and flag generation.
  always_comb begin
    y = '0;
    unique case (op)
      OP_ADD, OP_SUB, OP_CMP: y = sum[WIDTH-1:0];
      OP_AND:                 y = a & b;
      OP_OR:                  y = a | b;
      OP_XOR:                 y = a ^ b;
      OP_NOTA:                y = ~a;
      OP_PASSB:               y = b;
      default:                y = '0;
    endcase
    flags.cout = arith & sum[WIDTH];
    flags.zero = (y == '0);
    flags.neg  = y[WIDTH-1];
    // Signed overflow: both adder inputs share a sign that the result does not.
    flags.ovf  = arith & (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alun_pipe.sv
// Two-stage valid/ready ALU pipeline with optional accumulator.
// S1 holds the captured operation, S2 holds the computed result and flags.
module alun_pipe
  import alun_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit ACC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             use_acc,
  input  logic             acc_wr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  logic             s1_valid_q, s1_valid_d;
  op_e              s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_cin_q, s1_cin_d;
  logic             s1_use_acc_q, s1_use_acc_d;
  logic             s1_acc_wr_q, s1_acc_wr_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] y_q, y_d;
  flags_t           flags_q, flags_d;

  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s2_free;
  logic             accept;
  logic             advance;
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_y;
  flags_t           core_flags;

  // Handshake: S1 may move into S2 when S2 is empty or draining this cycle.
  always_comb begin
    s2_free  = !s2_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_free;
    accept   = in_valid && in_ready;
    advance  = s1_valid_q && s2_free;
    core_a   = (ACC_EN && s1_use_acc_q) ? acc_q : s1_a_q;
  end

  alun_core #(.WIDTH(WIDTH)) u_core (
    .op    (s1_op_q),
    .a     (core_a),
    .b     (s1_b_q),
    .cin   (s1_cin_q),
    .y     (core_y),
    .flags (core_flags)
  );

  // S1 capture on accept; empties when its op moves on without a replacement.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_op_d      = s1_op_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_cin_d     = s1_cin_q;
    s1_use_acc_d = s1_use_acc_q;
    s1_acc_wr_d  = s1_acc_wr_q;
    if (accept) begin
      s1_valid_d   = 1'b1;
      s1_op_d      = op_e'(op);
      s1_a_d       = a;
      s1_b_d       = b;
      s1_cin_d     = cin;
      s1_use_acc_d = use_acc && ACC_EN;
      s1_acc_wr_d  = acc_wr && ACC_EN;
    end else if (advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2 result register; held stable while the consumer stalls.
  always_comb begin
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    flags_d    = flags_q;
    if (advance) begin
      s2_valid_d = 1'b1;
      y_d        = core_y;
      flags_d    = core_flags;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // Accumulator updates on the S1->S2 transfer, so the next op in S1 sees it.
  always_comb begin
    acc_d = acc_q;
    if (ACC_EN && advance && s1_acc_wr_q && (s1_op_q != OP_CMP)) begin
      acc_d = core_y;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= OP_ADD;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_cin_q     <= 1'b0;
      s1_use_acc_q <= 1'b0;
      s1_acc_wr_q  <= 1'b0;
      s2_valid_q   <= 1'b0;
      y_q          <= '0;
      flags_q      <= '0;
      acc_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_cin_q     <= s1_cin_d;
      s1_use_acc_q <= s1_use_acc_d;
      s1_acc_wr_q  <= s1_acc_wr_d;
      s2_valid_q   <= s2_valid_d;
      y_q          <= y_d;
      flags_q      <= flags_d;
      acc_q        <= acc_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign y         = y_q;
  assign cout      = flags_q.cout;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign ovf       = flags_q.ovf;

endmodule

// File: tb/tb_alun_pipe.sv
// Self-checking bench for alun_pipe (WIDTH=4, accumulator enabled).
module tb_alun_pipe;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         cin, use_acc, acc_wr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         cout, zero, neg, ovf;

  alun_pipe #(.WIDTH(W), .ACC_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .cin(cin), .use_acc(use_acc), .acc_wr(acc_wr),
    .out_valid(out_valid), .out_ready(out_ready), .y(y),
    .cout(cout), .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] y;
    logic [3:0]   f;   // {cout, zero, neg, ovf}
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] y;
    logic [3:0]   f;
  } vec_t;

  exp_t   exp_q[$];
  exp_t   tbl_exp;
  logic   use_tbl;
  logic [W-1:0] macc;
  int     n_pass  = 0;
  int     n_total = 0;
  int     pops    = 0;
  int     accepts = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Reference model: integer arithmetic with explicit signed range test.
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z,
                                 input logic c);
    exp_t r;
    int ux, uz, ci, s, sx, sz, ss;
    logic ar;
    ar = (o == 3'd0) || (o == 3'd1) || (o == 3'd7);
    ux = int'(x);
    uz = (o == 3'd0) ? int'(z) : ((1 << W) - 1 - int'(z));
    ci = (o == 3'd7) ? 1 : int'(c);
    sx = (ux >= (1 << (W-1))) ? ux - (1 << W) : ux;
    sz = (uz >= (1 << (W-1))) ? uz - (1 << W) : uz;
    s  = ux + uz + ci;
    ss = sx + sz + ci;
    case (o)
      3'd2:    r.y = x & z;
      3'd3:    r.y = x | z;
      3'd4:    r.y = x ^ z;
      3'd5:    r.y = ~x;
      3'd6:    r.y = z;
      default: r.y = W'(s);
    endcase
    r.f[3] = ar && (s >= (1 << W));
    r.f[2] = (r.y == '0);
    r.f[1] = r.y[W-1];
    r.f[0] = ar && ((ss > (1 << (W-1)) - 1) || (ss < -(1 << (W-1))));
    return r;
  endfunction

  // One clock: score output transfer and input accept just before the edge.
  task automatic cycle();
    exp_t e, m;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      macc = '0;
    end else begin
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("y", 32'(y), 32'(e.y));
          chk("flags", 32'({cout, zero, neg, ovf}), 32'(e.f));
        end
      end
      if (in_valid && in_ready) begin
        accepts++;
        m = model(op, use_acc ? macc : a, b, cin);
        if (acc_wr && op != 3'd7) macc = m.y;
        exp_q.push_back(use_tbl ? tbl_exp : m);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z,
                      input logic c, input logic ua, input logic aw);
    int acc0;
    acc0     = accepts;
    in_valid = 1'b1;
    op = o; a = x; b = z; cin = c; use_acc = ua; acc_wr = aw;
    for (int t = 0; t < 20; t++) begin
      cycle();
      if (accepts != acc0) break;
    end
    if (accepts == acc0) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic send_tbl(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] z,
                          input logic c, input logic ua, input logic aw,
                          input logic [W-1:0] ey, input logic [3:0] ef);
    use_tbl = 1'b1;
    tbl_exp = '{y: ey, f: ef};
    send(o, x, z, c, ua, aw);
    use_tbl = 1'b0;
  endtask

  vec_t tbl[13];

  initial begin
    int p0, a0;
    tbl[0]  = '{3'd0, 4'h7, 4'h9, 1'b0, 4'h0, 4'b1100};
    tbl[1]  = '{3'd0, 4'h7, 4'h1, 1'b0, 4'h8, 4'b0011};
    tbl[2]  = '{3'd1, 4'h3, 4'h5, 1'b1, 4'hE, 4'b0010};
    tbl[3]  = '{3'd1, 4'h8, 4'h1, 1'b1, 4'h7, 4'b1001};
    tbl[4]  = '{3'd0, 4'h8, 4'h8, 1'b1, 4'h1, 4'b1001};
    tbl[5]  = '{3'd1, 4'h5, 4'h2, 1'b0, 4'h2, 4'b1000};
    tbl[6]  = '{3'd2, 4'hC, 4'hA, 1'b1, 4'h8, 4'b0010};
    tbl[7]  = '{3'd3, 4'h5, 4'hA, 1'b0, 4'hF, 4'b0010};
    tbl[8]  = '{3'd4, 4'hF, 4'hF, 1'b1, 4'h0, 4'b0100};
    tbl[9]  = '{3'd5, 4'h5, 4'h3, 1'b0, 4'hA, 4'b0010};
    tbl[10] = '{3'd6, 4'h9, 4'h3, 1'b1, 4'h3, 4'b0000};
    tbl[11] = '{3'd7, 4'h5, 4'h5, 1'b0, 4'h0, 4'b1100};
    tbl[12] = '{3'd7, 4'h2, 4'h7, 1'b0, 4'hB, 4'b0010};

    use_tbl = 1'b0; tbl_exp = '0; macc = '0;
    in_valid = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
    use_acc = 1'b0; acc_wr = 1'b0; out_ready = 1'b1;
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_flags", 32'({cout, zero, neg, ovf}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    idle(2);
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // Latency: accepted on edge k, visible after edge k+1
    send_tbl(3'd6, 4'h0, 4'h5, 1'b0, 1'b0, 1'b0, 4'h5, 4'b0000);
    chk("lat_k", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    cycle();
    chk("lat_k1", 32'(out_valid), 32'd1);
    idle(2);

    // Opcode/flag vectors, back to back
    foreach (tbl[i]) send_tbl(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, 1'b0,
                              tbl[i].y, tbl[i].f);
    idle(3);
    chk("tbl_drained", 32'(exp_q.size()), 32'd0);

    // Accumulator chain: operand a ignored, results on consecutive cycles
    p0 = pops;
    send_tbl(3'd0, 4'hF, 4'h3, 1'b0, 1'b1, 1'b1, 4'h3, 4'b0000);
    send_tbl(3'd0, 4'hF, 4'h3, 1'b0, 1'b1, 1'b1, 4'h6, 4'b0000);
    send_tbl(3'd0, 4'hF, 4'h3, 1'b0, 1'b1, 1'b1, 4'h9, 4'b0011);
    send_tbl(3'd0, 4'hF, 4'h3, 1'b0, 1'b1, 1'b1, 4'hC, 4'b0010);
    send_tbl(3'd0, 4'hF, 4'h3, 1'b0, 1'b1, 1'b1, 4'hF, 4'b0010);
    send_tbl(3'd0, 4'hF, 4'h3, 1'b0, 1'b1, 1'b1, 4'h2, 4'b1000);
    idle(1);
    chk("acc_chain_pops_early", 32'(pops - p0), 32'd5);
    idle(1);
    chk("acc_chain_pops", 32'(pops - p0), 32'd6);

    // CMP with acc_wr must leave acc (=2) untouched
    send_tbl(3'd7, 4'h5, 4'h1, 1'b0, 1'b0, 1'b1, 4'h4, 4'b1000);
    send_tbl(3'd0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h2, 4'b0000);
    idle(3);

    // Full stall: two accepts, then in_ready drops and outputs hold
    p0 = pops;
    out_ready = 1'b0;
    send(3'd0, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0);
    send(3'd4, 4'h6, 4'h3, 1'b0, 1'b0, 1'b1);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    a0 = accepts;
    in_valid = 1'b1;
    op = 3'd0; a = 4'h0; b = 4'h4; cin = 1'b0; use_acc = 1'b1; acc_wr = 1'b1;
    for (int t = 0; t < 5; t++) begin
      cycle();
      chk("stall_y_hold", 32'(y), 32'(exp_q[0].y));
      chk("stall_in_ready_hold", 32'(in_ready), 32'd0);
    end
    chk("stall_no_accept", 32'(accepts - a0), 32'd0);
    out_ready = 1'b1;
    send(3'd0, 4'h0, 4'h4, 1'b0, 1'b1, 1'b1);
    send(3'd3, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    send(3'd7, 4'h3, 4'h4, 1'b1, 1'b0, 1'b0);
    send(3'd5, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    idle(4);
    chk("stall_all_out", 32'(pops - p0), 32'd6);
    chk("stall_drained", 32'(exp_q.size()), 32'd0);

    // Reset with two ops in flight
    out_ready = 1'b0;
    send(3'd0, 4'h3, 4'h3, 1'b0, 1'b0, 1'b1);
    send(3'd0, 4'h1, 4'h1, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_y", 32'(y), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    send_tbl(3'd0, 4'h9, 4'h1, 1'b0, 1'b1, 1'b0, 4'h1, 4'b0000);
    idle(4);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
